// File: rtl/run_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// run_ctrl: run/stop/single-step sequencer producing the CPU clock enable;
// optional fetch-address breakpoint when RUN_CTRL_BREAKPOINT_EN is defined.  Rev 1.0
// ------------------------------------------------------------------------
module run_ctrl #(
  parameter int AW          = 32,
  parameter int CW          = 32,
  parameter int STEP_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          btn_run,
  input  logic          btn_stop,
  input  logic          btn_step,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] bp_addr,
  input  logic          bp_en,
  output logic          cpu_ce,
  output logic [1:0]    state,
  output logic          halted_bp,
  output logic [CW-1:0] cycles
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_BRK  = 2'd3;

  localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES);

  logic [1:0]    state_q, state_d;
  logic          cpu_ce_q, cpu_ce_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [7:0]    stepcnt_q, stepcnt_d;
  logic          prev_run_q, prev_stop_q, prev_step_q;

  logic          press_run, press_stop, press_step;
  logic          idle_state;
  logic          bp_hit;
  logic          fire;

  assign press_run  = btn_run  & ~prev_run_q;
  assign press_stop = btn_stop & ~prev_stop_q;
  assign press_step = btn_step & ~prev_step_q;

  // States from which run/step presses are accepted.
  assign idle_state = (state_q == ST_STOP) || (state_q == ST_BRK);

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic skip_q, skip_d;

  // skip lets the instruction sitting on the breakpoint execute once after a resume.
  assign bp_hit = bp_en && !skip_q && (addr == bp_addr);
`else
  logic unused_bp_inputs;

  assign unused_bp_inputs = ^{addr, bp_addr, bp_en};
  assign bp_hit           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_STOP;
      cpu_ce_q  <= 1'b0;
      cycles_q  <= '0;
      stepcnt_q <= 8'd0;
`ifdef RUN_CTRL_BREAKPOINT_EN
      skip_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cpu_ce_q  <= cpu_ce_d;
      cycles_q  <= cycles_d;
      stepcnt_q <= stepcnt_d;
`ifdef RUN_CTRL_BREAKPOINT_EN
      skip_q    <= skip_d;
`endif
    end
    // Loading the live level during reset suppresses a press from a held button.
    prev_run_q  <= btn_run;
    prev_stop_q <= btn_stop;
    prev_step_q <= btn_step;
  end

  always_comb begin
    state_d   = state_q;
    stepcnt_d = stepcnt_q;
    fire      = 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    skip_d    = skip_q;
`endif
    if (press_stop) begin
      state_d = ST_STOP;
    end else if (press_step && idle_state) begin
      state_d   = ST_STEP;
      stepcnt_d = STEP_LOAD;
`ifdef RUN_CTRL_BREAKPOINT_EN
      skip_d    = 1'b1;
`endif
    end else if (press_run && idle_state) begin
      state_d = ST_RUN;
`ifdef RUN_CTRL_BREAKPOINT_EN
      skip_d  = 1'b1;
`endif
    end else if (tick && (state_q == ST_RUN)) begin
      if (bp_hit) begin
        state_d = ST_BRK;
      end else begin
        fire = 1'b1;
`ifdef RUN_CTRL_BREAKPOINT_EN
        skip_d = 1'b0;
`endif
      end
    end else if (tick && (state_q == ST_STEP)) begin
      fire      = 1'b1;
      stepcnt_d = stepcnt_q - 8'd1;
      if (stepcnt_q == 8'd1) begin
        state_d = ST_STOP;
      end
    end
  end

  always_comb begin
    cpu_ce_d = fire;
    cycles_d = cycles_q + CW'(fire);
  end

  assign cpu_ce = cpu_ce_q;
  assign state  = state_q;
  assign cycles = cycles_q;

`ifdef RUN_CTRL_BREAKPOINT_EN
  assign halted_bp = (state_q == ST_BRK);
`else
  assign halted_bp = 1'b0;
`endif

endmodule
`default_nettype wire
